// File: rtl/batch_dispatcher_pkg.sv
// Shared widths and dispatcher state encoding for the DRAM scheduler batch path.
package batch_dispatcher_pkg;

  localparam int unsigned SBR_ID_WIDTH     = 4;
  localparam int unsigned SRR_ID_WIDTH     = 4;
  localparam int unsigned REQUEST_ID_WIDTH = 5;
  localparam int unsigned BANK_GROUP_WIDTH = 2;
  localparam int unsigned BANK_WIDTH       = 2;
  localparam int unsigned ROW_WIDTH        = 8;

  typedef enum logic [2:0] {
    DISP_IDLE,
    DISP_LOAD_SBR,
    DISP_LOAD_SRR,
    DISP_LOAD_REQ,
    DISP_ISSUE,
    DISP_DONE
  } disp_state_t;

  function automatic logic is_load_state(input disp_state_t s);
    return (s == DISP_LOAD_SBR) || (s == DISP_LOAD_SRR) || (s == DISP_LOAD_REQ);
  endfunction

endpackage

// File: rtl/batch_dispatcher_rd_wait.sv
// Read-latency countdown shared by all table LOAD states; strobes capture when
// the registered read address has had RD_LAT cycles to produce data.
module dispatch_rd_wait #(
  parameter int unsigned RD_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  output logic capture
);

  localparam int unsigned CW = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);

  logic [CW-1:0] cnt;

  // Reload on capture so back-to-back LOAD states each get a full wait.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= CW'(RD_LAT);
    end else if (!active || cnt == '0) begin
      cnt <= CW'(RD_LAT);
    end else begin
      cnt <= cnt - CW'(1);
    end
  end

  assign capture = active && (cnt == '0);

endmodule

// File: rtl/batch_dispatcher.sv
// Walks one SBR -> SRR chain -> request chain and issues each request in order.
module batch_dispatcher
  import batch_dispatcher_pkg::*;
#(
  parameter int unsigned RD_LAT = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [SBR_ID_WIDTH-1:0]     critical_path_sbr,
  output logic                        busy,
  output logic                        done,
  output logic [SBR_ID_WIDTH-1:0]     sbr_rd_addr,
  input  logic [SRR_ID_WIDTH-1:0]     sbr_rd_head_srr,
  input  logic [SRR_ID_WIDTH-1:0]     sbr_rd_row_count,
  input  logic [BANK_GROUP_WIDTH-1:0] sbr_rd_bank_group,
  input  logic [BANK_WIDTH-1:0]       sbr_rd_bank,
  output logic [SRR_ID_WIDTH-1:0]     srr_rd_addr,
  input  logic [REQUEST_ID_WIDTH-1:0] srr_rd_head_req,
  input  logic [REQUEST_ID_WIDTH-1:0] srr_rd_count,
  input  logic [SRR_ID_WIDTH-1:0]     srr_rd_next,
  output logic [REQUEST_ID_WIDTH-1:0] req_rd_addr,
  input  logic [ROW_WIDTH-1:0]        req_rd_row,
  input  logic [REQUEST_ID_WIDTH-1:0] req_rd_next,
  input  logic                        issue_ready,
  output logic                        issue_valid,
  output logic [REQUEST_ID_WIDTH-1:0] issue_req_id,
  output logic [BANK_GROUP_WIDTH-1:0] issue_bank_group,
  output logic [BANK_WIDTH-1:0]       issue_bank,
  output logic [ROW_WIDTH-1:0]        issue_row,
  output logic                        issue_row_first,
  output logic                        issue_last
);

  localparam logic [SRR_ID_WIDTH-1:0]     ROWS_ONE = 1;
  localparam logic [REQUEST_ID_WIDTH-1:0] REQS_ONE = 1;

  disp_state_t                 state;
  logic [SRR_ID_WIDTH-1:0]     rows_left;
  logic [REQUEST_ID_WIDTH-1:0] reqs_left;
  logic [SRR_ID_WIDTH-1:0]     srr_next;
  logic [REQUEST_ID_WIDTH-1:0] req_next;
  logic                        in_load;
  logic                        capture;

  assign in_load = is_load_state(state);

  dispatch_rd_wait #(.RD_LAT(RD_LAT)) u_rd_wait (
    .clk     (clk),
    .rst     (rst),
    .active  (in_load),
    .capture (capture)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= DISP_IDLE;
      rows_left        <= '0;
      reqs_left        <= '0;
      srr_next         <= '0;
      req_next         <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      sbr_rd_addr      <= '0;
      srr_rd_addr      <= '0;
      req_rd_addr      <= '0;
      issue_valid      <= 1'b0;
      issue_req_id     <= '0;
      issue_bank_group <= '0;
      issue_bank       <= '0;
      issue_row        <= '0;
      issue_row_first  <= 1'b0;
      issue_last       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        DISP_IDLE: begin
          if (start) begin
            sbr_rd_addr <= critical_path_sbr;
            busy        <= 1'b1;
            state       <= DISP_LOAD_SBR;
          end
        end
        DISP_LOAD_SBR: begin
          if (capture) begin
            issue_bank_group <= sbr_rd_bank_group;
            issue_bank       <= sbr_rd_bank;
            rows_left        <= sbr_rd_row_count;
            if (sbr_rd_row_count == '0) begin
              done  <= 1'b1;
              state <= DISP_DONE;
            end else begin
              srr_rd_addr <= sbr_rd_head_srr;
              state       <= DISP_LOAD_SRR;
            end
          end
        end
        DISP_LOAD_SRR: begin
          if (capture) begin
            reqs_left       <= srr_rd_count;
            srr_next        <= srr_rd_next;
            issue_row_first <= 1'b1;
            // An empty SRR still consumes one row of the SBR's budget.
            if (srr_rd_count == '0) begin
              if (rows_left > ROWS_ONE) begin
                rows_left   <= rows_left - ROWS_ONE;
                srr_rd_addr <= srr_rd_next;
              end else begin
                rows_left <= '0;
                done      <= 1'b1;
                state     <= DISP_DONE;
              end
            end else begin
              req_rd_addr <= srr_rd_head_req;
              state       <= DISP_LOAD_REQ;
            end
          end
        end
        DISP_LOAD_REQ: begin
          if (capture) begin
            issue_row    <= req_rd_row;
            req_next     <= req_rd_next;
            issue_req_id <= req_rd_addr;
            issue_last   <= (reqs_left == REQS_ONE) && (rows_left == ROWS_ONE);
            issue_valid  <= 1'b1;
            state        <= DISP_ISSUE;
          end
        end
        DISP_ISSUE: begin
          if (issue_ready) begin
            issue_valid <= 1'b0;
            issue_last  <= 1'b0;
            reqs_left   <= reqs_left - REQS_ONE;
            if (reqs_left > REQS_ONE) begin
              issue_row_first <= 1'b0;
              req_rd_addr     <= req_next;
              state           <= DISP_LOAD_REQ;
            end else if (rows_left > ROWS_ONE) begin
              rows_left   <= rows_left - ROWS_ONE;
              srr_rd_addr <= srr_next;
              state       <= DISP_LOAD_SRR;
            end else begin
              rows_left       <= '0;
              issue_row_first <= 1'b0;
              done            <= 1'b1;
              state           <= DISP_DONE;
            end
          end
        end
        DISP_DONE: begin
          busy  <= 1'b0;
          state <= DISP_IDLE;
        end
        default: state <= DISP_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_batch_dispatcher.sv
// Scoreboard bench for batch_dispatcher: table model with RD_LAT read pipelines.
module tb_batch_dispatcher;
  import batch_dispatcher_pkg::*;

  localparam int unsigned RD_LAT = 2;

  logic                        clk;
  logic                        rst;
  logic                        start;
  logic [SBR_ID_WIDTH-1:0]     critical_path_sbr;
  logic                        busy;
  logic                        done;
  logic [SBR_ID_WIDTH-1:0]     sbr_rd_addr;
  logic [SRR_ID_WIDTH-1:0]     sbr_rd_head_srr;
  logic [SRR_ID_WIDTH-1:0]     sbr_rd_row_count;
  logic [BANK_GROUP_WIDTH-1:0] sbr_rd_bank_group;
  logic [BANK_WIDTH-1:0]       sbr_rd_bank;
  logic [SRR_ID_WIDTH-1:0]     srr_rd_addr;
  logic [REQUEST_ID_WIDTH-1:0] srr_rd_head_req;
  logic [REQUEST_ID_WIDTH-1:0] srr_rd_count;
  logic [SRR_ID_WIDTH-1:0]     srr_rd_next;
  logic [REQUEST_ID_WIDTH-1:0] req_rd_addr;
  logic [ROW_WIDTH-1:0]        req_rd_row;
  logic [REQUEST_ID_WIDTH-1:0] req_rd_next;
  logic                        issue_ready;
  logic                        issue_valid;
  logic [REQUEST_ID_WIDTH-1:0] issue_req_id;
  logic [BANK_GROUP_WIDTH-1:0] issue_bank_group;
  logic [BANK_WIDTH-1:0]       issue_bank;
  logic [ROW_WIDTH-1:0]        issue_row;
  logic                        issue_row_first;
  logic                        issue_last;

  batch_dispatcher #(.RD_LAT(RD_LAT)) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .critical_path_sbr (critical_path_sbr),
    .busy              (busy),
    .done              (done),
    .sbr_rd_addr       (sbr_rd_addr),
    .sbr_rd_head_srr   (sbr_rd_head_srr),
    .sbr_rd_row_count  (sbr_rd_row_count),
    .sbr_rd_bank_group (sbr_rd_bank_group),
    .sbr_rd_bank       (sbr_rd_bank),
    .srr_rd_addr       (srr_rd_addr),
    .srr_rd_head_req   (srr_rd_head_req),
    .srr_rd_count      (srr_rd_count),
    .srr_rd_next       (srr_rd_next),
    .req_rd_addr       (req_rd_addr),
    .req_rd_row        (req_rd_row),
    .req_rd_next       (req_rd_next),
    .issue_ready       (issue_ready),
    .issue_valid       (issue_valid),
    .issue_req_id      (issue_req_id),
    .issue_bank_group  (issue_bank_group),
    .issue_bank        (issue_bank),
    .issue_row         (issue_row),
    .issue_row_first   (issue_row_first),
    .issue_last        (issue_last)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Table contents
  logic [3:0] t_sbr_head [16];
  logic [3:0] t_sbr_rows [16];
  logic [1:0] t_sbr_bg   [16];
  logic [1:0] t_sbr_bank [16];
  logic [4:0] t_srr_head [16];
  logic [4:0] t_srr_cnt  [16];
  logic [3:0] t_srr_next [16];
  logic [7:0] t_req_row  [32];
  logic [4:0] t_req_next [32];

  logic [11:0] sbr_pipe [RD_LAT];
  logic [13:0] srr_pipe [RD_LAT];
  logic [12:0] req_pipe [RD_LAT];

  always @(posedge clk) begin
    sbr_pipe[0] <= {t_sbr_head[sbr_rd_addr], t_sbr_rows[sbr_rd_addr], t_sbr_bg[sbr_rd_addr], t_sbr_bank[sbr_rd_addr]};
    srr_pipe[0] <= {t_srr_head[srr_rd_addr], t_srr_cnt[srr_rd_addr], t_srr_next[srr_rd_addr]};
    req_pipe[0] <= {t_req_row[req_rd_addr], t_req_next[req_rd_addr]};
    for (int i = 1; i < RD_LAT; i++) begin
      sbr_pipe[i] <= sbr_pipe[i-1];
      srr_pipe[i] <= srr_pipe[i-1];
      req_pipe[i] <= req_pipe[i-1];
    end
  end

  assign {sbr_rd_head_srr, sbr_rd_row_count, sbr_rd_bank_group, sbr_rd_bank} = sbr_pipe[RD_LAT-1];
  assign {srr_rd_head_req, srr_rd_count, srr_rd_next} = srr_pipe[RD_LAT-1];
  assign {req_rd_row, req_rd_next} = req_pipe[RD_LAT-1];

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int unsigned id;
    int unsigned bg;
    int unsigned bank;
    int unsigned row;
    bit          first;
    bit          last;
  } exp_t;

  exp_t sb [$];

  task automatic push_expected(input int unsigned s);
    int unsigned srr, q, rows, c;
    exp_t e;
    rows = t_sbr_rows[s];
    srr  = t_sbr_head[s];
    for (int unsigned r = 0; r < rows; r++) begin
      c = t_srr_cnt[srr];
      q = t_srr_head[srr];
      for (int unsigned k = 0; k < c; k++) begin
        e.id    = q;
        e.bg    = t_sbr_bg[s];
        e.bank  = t_sbr_bank[s];
        e.row   = t_req_row[q];
        e.first = (k == 0);
        e.last  = (r == rows - 1) && (k == c - 1);
        sb.push_back(e);
        q = t_req_next[q];
      end
      srr = t_srr_next[srr];
    end
  endtask

  // Cycle counter, ready driver and output monitor
  int unsigned cyc = 0;
  int unsigned dones = 0;
  bit          stall_mode = 0;
  int unsigned stall_cnt = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    issue_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (stall_mode && issue_valid && stall_cnt < 5) begin
        issue_ready = 1'b0;
        stall_cnt++;
      end else begin
        issue_ready = 1'b1;
      end
    end
  end

  initial begin
    exp_t        e;
    bit          held = 0;
    logic [18:0] held_payload = '0;
    logic [18:0] payload;
    int unsigned last_hs = 0;
    forever begin
      @(negedge clk);
      payload = {issue_req_id, issue_bank_group, issue_bank, issue_row, issue_row_first, issue_last};
      if (rst) begin
        held = 0;
      end else begin
        if (done) dones++;
        if (held) begin
          chk("hold_valid", issue_valid, 1);
          chk("hold_payload", payload, held_payload);
        end
        if (issue_valid && issue_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_issue", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("issue_id", issue_req_id, e.id);
            chk("issue_bg", issue_bank_group, e.bg);
            chk("issue_bank", issue_bank, e.bank);
            chk("issue_row", issue_row, e.row);
            chk("issue_row_first", issue_row_first, e.first);
            chk("issue_last", issue_last, e.last);
            if (!e.first && !stall_mode) chk("issue_gap", cyc - last_hs, RD_LAT + 2);
          end
          last_hs = cyc;
          held    = 0;
        end else if (issue_valid) begin
          held         = 1;
          held_payload = payload;
        end else begin
          held = 0;
        end
      end
    end
  end

  task automatic run_case(input logic [3:0] sbr, input int unsigned spurious, output int unsigned lat);
    int unsigned d0;
    d0 = dones;
    push_expected(sbr);
    critical_path_sbr = sbr;
    start = 1'b1;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
      start = (lat == spurious);
      if (start) critical_path_sbr = sbr ^ 4'h1;
      @(negedge clk);
    end while (!done && lat < 2000);
    start = 1'b0;
    chk("done_seen", done, 1);
    chk("busy_at_done", busy, 1);
    @(posedge clk);
    @(negedge clk);
    chk("busy_after_done", busy, 0);
    chk("done_one_cycle", done, 0);
    chk("done_count", dones - d0, 1);
    chk("queue_empty", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    int unsigned lat;
    int unsigned n;
    rst = 1'b1;
    start = 1'b0;
    critical_path_sbr = '0;
    for (int i = 0; i < 16; i++) begin
      t_sbr_head[i] = '0; t_sbr_rows[i] = '0; t_sbr_bg[i] = '0; t_sbr_bank[i] = '0;
      t_srr_head[i] = '0; t_srr_cnt[i] = '0;  t_srr_next[i] = '0;
    end
    for (int i = 0; i < 32; i++) begin
      t_req_row[i]  = 8'(i * 3 + 1);
      t_req_next[i] = 5'((i + 9) % 32);
    end
    // SBR 1: one SRR with requests 4 -> 7 -> 2
    t_sbr_head[1] = 4'd3; t_sbr_rows[1] = 4'd1; t_sbr_bg[1] = 2'd2; t_sbr_bank[1] = 2'd1;
    t_srr_head[3] = 5'd4; t_srr_cnt[3] = 5'd3; t_srr_next[3] = 4'd9;
    t_req_row[4] = 8'h11; t_req_next[4] = 5'd7;
    t_req_row[7] = 8'h22; t_req_next[7] = 5'd2;
    t_req_row[2] = 8'h33; t_req_next[2] = 5'd31;
    // SBR 2: SRR 5 (10 -> 12) then SRR 6 (20)
    t_sbr_head[2] = 4'd5; t_sbr_rows[2] = 4'd2; t_sbr_bg[2] = 2'd1; t_sbr_bank[2] = 2'd3;
    t_srr_head[5] = 5'd10; t_srr_cnt[5] = 5'd2; t_srr_next[5] = 4'd6;
    t_srr_head[6] = 5'd20; t_srr_cnt[6] = 5'd1; t_srr_next[6] = 4'd0;
    t_req_row[10] = 8'h40; t_req_next[10] = 5'd12;
    t_req_row[12] = 8'h41; t_req_next[12] = 5'd0;
    t_req_row[20] = 8'h50; t_req_next[20] = 5'd0;
    // SBR 3: empty SRR 7 skipped, then SRR 5
    t_sbr_head[3] = 4'd7; t_sbr_rows[3] = 4'd2; t_sbr_bg[3] = 2'd3; t_sbr_bank[3] = 2'd0;
    t_srr_head[7] = 5'd15; t_srr_cnt[7] = 5'd0; t_srr_next[7] = 4'd5;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_issue_valid", issue_valid, 0);
    chk("rst_issue_last", issue_last, 0);
    chk("rst_sbr_addr", sbr_rd_addr, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    run_case(4'd1, 0, lat);
    run_case(4'd2, 0, lat);
    run_case(4'd3, 0, lat);

    stall_cnt  = 0;
    stall_mode = 1;
    run_case(4'd1, 0, lat);
    chk("stall_cycles", stall_cnt, 5);
    stall_mode = 0;

    run_case(4'd0, 0, lat);
    chk("empty_done_latency", lat, RD_LAT + 2);

    // Reset while an issue is pending
    push_expected(2);
    critical_path_sbr = 4'd2;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!issue_valid && n < 100);
    chk("rst_reach_issue", issue_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_issue_valid", issue_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("midrst_done_hold", done, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    run_case(4'd2, 0, lat);

    run_case(4'd1, 3, lat);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/batch_dispatcher.md
BATCH_DISPATCHER -- requirements
Module: batch_dispatcher

Interface
REQ-001 Parameter RD_LAT, default 2: cycles from a registered table read address to valid read data.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-high. Ports: clk (input, 1, rising-edge clock); rst (input, 1, async active-high reset).
REQ-003 Control inputs: start (1, begin dispatch pulse); critical_path_sbr (SBR_ID_WIDTH, SBR to drain, sampled with start).
REQ-004 Control outputs: busy (1, high from cycle after start until done); done (1, one-cycle completion pulse).
REQ-005 SBR read port: sbr_rd_addr (output, SBR_ID_WIDTH); inputs sbr_rd_head_srr (SRR_ID_WIDTH), sbr_rd_row_count (SRR_ID_WIDTH), sbr_rd_bank_group (BANK_GROUP_WIDTH), sbr_rd_bank (BANK_WIDTH).
REQ-006 SRR read port: srr_rd_addr (output, SRR_ID_WIDTH); inputs srr_rd_head_req (REQUEST_ID_WIDTH), srr_rd_count (REQUEST_ID_WIDTH), srr_rd_next (SRR_ID_WIDTH, chain link).
REQ-007 Request read port: req_rd_addr (output, REQUEST_ID_WIDTH); inputs req_rd_row (ROW_WIDTH), req_rd_next (REQUEST_ID_WIDTH, chain link).
REQ-008 Issue handshake: input issue_ready (1); output issue_valid (1).
REQ-009 Issue payload outputs: issue_req_id (REQUEST_ID_WIDTH), issue_bank_group, issue_bank, issue_row (ROW_WIDTH).
REQ-010 Issue flag outputs: issue_row_first (1, first request of an SRR, ACT needed); issue_last (1, final request of batch).

Function
REQ-011 State machine SHALL have states IDLE, LOAD_SBR, LOAD_SRR, LOAD_REQ, ISSUE, DONE.
REQ-012 IDLE -> LOAD_SBR on start; latch critical_path_sbr; start while busy is ignored.
REQ-013 Each LOAD state registers its read address, waits RD_LAT cycles, then captures the read data.
REQ-014 LOAD_SBR: capture head_srr, row_count, bank_group, bank; rows_left = row_count; row_count==0 -> DONE with no issue.
REQ-015 LOAD_SRR: capture head_req, count, next; reqs_left = count; set row_first; count==0 skips the row: decrement rows_left, then follow next or go DONE.
REQ-016 LOAD_REQ: capture row and next, then -> ISSUE.
REQ-017 ISSUE: issue_valid=1; payload and flags held stable until issue_valid and issue_ready are both high in the same cycle.
REQ-018 On handshake with reqs_left>1: decrement reqs_left, clear row_first, follow req_next, -> LOAD_REQ.
REQ-019 On handshake with reqs_left==1 and rows_left>1: decrement rows_left, follow srr_next, -> LOAD_SRR.
REQ-020 issue_last SHALL equal (reqs_left==1 && rows_left==1) during ISSUE; on that handshake -> DONE.
REQ-021 DONE: done=1 for exactly one cycle, -> IDLE; busy falls the cycle after done.
REQ-022 issue_ready while issue_valid is low SHALL have no effect; issue_valid is never dropped before handshake.
REQ-023 Chain traversal SHALL be count-driven; link values are not tested for a terminator.
REQ-024 Counters SHALL be SRR_ID_WIDTH (rows_left) and REQUEST_ID_WIDTH (reqs_left) wide and never wrap below zero.
REQ-025 Minimum issue interval SHALL be RD_LAT+2 cycles per request with issue_ready held high.

Reset
REQ-026 rst asserted in any state SHALL force IDLE and zero all outputs and counters on the next evaluation, with no done pulse.
REQ-027 After rst deasserts, the block SHALL accept start on the first clock edge.

Structure
REQ-028 Width macros and state encodings (DISP_IDLE..DISP_DONE) SHALL live in the shared dram_scheduler_types header.
REQ-029 A single sub-module, dispatch_rd_wait (RD_LAT countdown with data-capture strobe), SHALL be shared by the three LOAD states.

Verification
REQ-030 SBR row_count=1, SRR count=3, requests 4->7->2, issue_ready=1 -> ids 4,7,2; row_first only on 4; issue_last only on 2; one done.
REQ-031 Two SRRs (counts 2,1) -> 3 issues; row_first on the 1st and 3rd; bank_group/bank constant across all issues.
REQ-032 issue_ready low for 5 cycles during ISSUE -> issue_valid and payload held stable, no skipped or duplicated id.
REQ-033 row_count=0 -> no issue_valid; done 1+RD_LAT+1 cycles after start.
REQ-034 rst pulsed mid-ISSUE -> issue_valid=0, busy=0, no done; a new start then completes normally.
REQ-035 start pulsed while busy -> ignored; issued sequence unchanged.
